mc_spram_mi: RTL and testbench
==============================

# mc_spram_mi

Memory-interface (mi_*) responder backed by the iCE40UP on-chip SPRAM. It is the target-side counterpart of the cache core's mi_* initiator port, and a drop-in alternative to the HyperRAM controller for boards without external RAM or for a fast low-memory region. It accepts cache line fill and writeback bursts and serves them at one 32-bit word per cycle.

## Interface
- AW, 15: word-address width actually decoded (15 gives 32K words = 128 KiB = four SPRAM macros as two 32-bit banks).
- clk  in  1  system clock (clk_1x domain).
- rst  in  1  reset, synchronous, active-high.
- mi_addr  in  24  burst start word address; bits above AW-1 ignored (aliasing).
- mi_len  in  7  burst length minus one (1..128 words).
- mi_rw  in  1  1 = read, 0 = write.
- mi_linear  in  1  1 = incrementing burst, 0 = wrapping burst.
- mi_valid  in  1  command valid.
- mi_ready  out  1  command accepted when mi_valid & mi_ready.
- mi_wdata  in  32  write data, must be valid whenever mi_wack is high.
- mi_wmsk  in  4  per-byte mask; bit set = byte NOT written.
- mi_wack  out  1  write word consumed this cycle.
- mi_wlast  out  1  high with the final mi_wack of a burst.
- mi_rdata  out  32  read data, qualified by mi_rstb.
- mi_rstb  out  1  read word valid this cycle.
- mi_rlast  out  1  high with the final mi_rstb of a burst.

## Operation
- FSM states: IDLE, RD, WR. Reset → IDLE.
- IDLE: mi_ready = 1. On mi_valid: latch address, len, linear flag into working registers, word counter = mi_len; go to RD if mi_rw else WR.
- RD: every cycle present the current address to SPRAM with write-enable low and push a "valid/last" token into a 1-stage pipeline; decrement counter, advance address. When counter == 0, the token carries last; go to IDLE.
- WR: mi_wack = 1 every cycle; SPRAM write of mi_wdata at the current address with nibble-enables derived from ~mi_wmsk; mi_wlast = (counter == 0); decrement and advance. When counter == 0 go to IDLE.
- Address advance: linear → addr + 1 modulo 2^AW. Wrapping → low bits inside mask (len rounded up to a power of two, minus one) increment and wrap; upper bits held. Non-power-of-two len in wrap mode: mask uses the next power of two; the burst still ends after len+1 words.
- Out-of-range high address bits alias silently; no error response exists.

## Timing
- Reset values: mi_ready 0 during reset, then 1 (IDLE) from the first cycle after rst falls; mi_wack, mi_wlast, mi_rstb, mi_rlast 0; mi_rdata 0.
- Command accepted at edge T. Read: first mi_rstb in cycle T+2, then len+1 consecutive strobes with no gaps; mi_rlast with the last. Write: mi_wack in cycles T+1 .. T+1+len, contiguous.
- mi_ready returns high the cycle after the last RD/WR cycle; a new command may be accepted while the previous read's final mi_rstb is still in the output stage (pipelined back-to-back; no overlap hazard because SPRAM returns data in order).
- Read-after-write to the same address on back-to-back commands returns the new data (write has completed at the SPRAM edge before the read address is issued).
- All outputs are registered or decoded from state registers only; no combinational path from mi_valid to any output.
- rst mid-burst: next cycle FSM in IDLE, strobes and pipeline token cleared, partial write not rolled back, SPRAM contents preserved.

## Configuration
- MC_SPRAM_WRAP_EN defined: wrapping bursts (mi_linear = 0) honoured as above.
- Not defined: mi_linear ignored, every burst increments linearly; wrap-mask logic removed.

## Structure
- Shared package: FSM state encodings, mi_len width (7), mi address width (24), SPRAM nibble-enable mapping constant.
- One sub-module: mc_spram_bank, 32-bit-wide bank built from two SB_SPRAM256KA side by side (16K words each), selected by address bit 14; wraps read/write/mask-to-nibble mapping and provides a behavioural model under SIM.

## Test plan
- Write 16 words 0xA0000000+i at 0x000100 (len=15, linear), then read back same → 16 contiguous mi_rstb from T+2, data matches, mi_rlast on 16th only.
- Write 0xFFFFFFFF to 0x000200, then 0x12345678 with mi_wmsk=4'b0101 → read returns 0x12FF56FF.
- With MC_SPRAM_WRAP_EN: read len=7 wrap from 0x000105 → address order 5,6,7,0,1,2,3,4 within block 0x000100; without macro → 0x105..0x10C.
- Two reads issued back-to-back (mi_valid held) → rstb stream contiguous except a single idle cycle between bursts, rlast twice.
- Assert rst during the 4th wack of a 16-word write → next cycle mi_wack=0, mi_ready=1 after rst falls; words 0..3 readable, word 4+ unchanged.
- Write at 0x008100 (AW=15) then read 0x000100 → same data (aliasing).

Source files
------------

// File: rtl/mc_spram_mi_pkg.sv
// rtl/mc_spram_mi_pkg.sv - shared types, widths and mask helpers for the SPRAM mi_* responder
package mc_spram_mi_pkg;
  localparam int MI_AW        = 24;
  localparam int MI_LW        = 7;
  localparam int BANK_AW      = 14;
  localparam int NIB_PER_BYTE = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  // mi byte mask is active-high "keep"; SPRAM nibble enables are active-high "write"
  function automatic logic [7:0] wmsk_to_nib(input logic [3:0] wmsk);
    logic [7:0] nib;
    nib = '0;
    for (int b = 0; b < 4; b++)
      nib[b*NIB_PER_BYTE +: NIB_PER_BYTE] = {NIB_PER_BYTE{~wmsk[b]}};
    return nib;
  endfunction

  // smear the length down to the next power of two minus one
  function automatic logic [MI_LW-1:0] wrap_mask(input logic [MI_LW-1:0] len);
    logic [MI_LW-1:0] m;
    m = len | (len >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction
endpackage

// File: rtl/mc_spram_bank.sv
// rtl/mc_spram_bank.sv - 16K x 32 bank of two SB_SPRAM256KA side by side, behavioural model outside synthesis
module mc_spram_bank (
  input  logic        clk,
  input  logic [13:0] addr,
  input  logic [31:0] wdata,
  input  logic [7:0]  nib_en,
  input  logic        we,
  input  logic        cs,
  output logic [31:0] rdata
);
`ifdef SYNTHESIS
  for (genvar h = 0; h < 2; h++) begin : g_half
    SB_SPRAM256KA u_spram (
      .ADDRESS    (addr),
      .DATAIN     (wdata[16*h +: 16]),
      .MASKWREN   (nib_en[4*h +: 4]),
      .WREN       (we),
      .CHIPSELECT (cs),
      .CLOCK      (clk),
      .STANDBY    (1'b0),
      .SLEEP      (1'b0),
      .POWEROFF   (1'b1),
      .DATAOUT    (rdata[16*h +: 16])
    );
  end
`else
  logic [31:0] mem [0:16383];

  // output register holds its value across writes, like the hard macro
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int n = 0; n < 8; n++)
          if (nib_en[n]) mem[addr][4*n +: 4] <= wdata[4*n +: 4];
      end else begin
        rdata <= mem[addr];
      end
    end
  end
`endif
endmodule

// File: rtl/mc_spram_mi.sv
// rtl/mc_spram_mi.sv - mi_* burst responder on iCE40UP SPRAM; MC_SPRAM_WRAP_EN enables wrapping bursts
module mc_spram_mi
  import mc_spram_mi_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MI_AW-1:0] mi_addr,
  input  logic [MI_LW-1:0] mi_len,
  input  logic             mi_rw,
  input  logic             mi_linear,
  input  logic             mi_valid,
  output logic             mi_ready,
  input  logic [31:0]      mi_wdata,
  input  logic [3:0]       mi_wmsk,
  output logic             mi_wack,
  output logic             mi_wlast,
  output logic [31:0]      mi_rdata,
  output logic             mi_rstb,
  output logic             mi_rlast
);
  localparam int BW = AW - BANK_AW;
  localparam int NB = 1 << BW;

  state_t           state;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    addr_nxt;
  logic [MI_LW-1:0] cnt_q;
  logic             ready_q, wack_q, wlast_q, rstb_q, rlast_q;
  logic [BW-1:0]    rd_sel_q;
  logic [31:0]      bank_rd [NB];
  logic [7:0]       nib_en;
  logic             unused_hi;

`ifdef MC_SPRAM_WRAP_EN
  logic [AW-1:0] mask_q;

  // mask is all ones for linear bursts, so one expression covers both modes
  assign addr_nxt  = (addr_q & ~mask_q) | ((addr_q + 1'b1) & mask_q);
  assign unused_hi = ^mi_addr[MI_AW-1:AW];
`else
  assign addr_nxt  = addr_q + 1'b1;
  assign unused_hi = ^{mi_addr[MI_AW-1:AW], mi_linear};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      wack_q   <= 1'b0;
      wlast_q  <= 1'b0;
      rstb_q   <= 1'b0;
      rlast_q  <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      rd_sel_q <= '0;
`ifdef MC_SPRAM_WRAP_EN
      mask_q   <= '1;
`endif
    end else begin
      rstb_q  <= (state == ST_RD);
      rlast_q <= (state == ST_RD) && (cnt_q == '0);
      if (state == ST_RD) rd_sel_q <= addr_q[AW-1:BANK_AW];
      case (state)
        ST_IDLE: begin
          if (mi_valid && ready_q) begin
            addr_q  <= mi_addr[AW-1:0];
            cnt_q   <= mi_len;
            ready_q <= 1'b0;
`ifdef MC_SPRAM_WRAP_EN
            mask_q  <= mi_linear ? '1 : AW'(wrap_mask(mi_len));
`endif
            if (mi_rw) begin
              state <= ST_RD;
            end else begin
              state   <= ST_WR;
              wack_q  <= 1'b1;
              wlast_q <= (mi_len == '0);
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_RD, ST_WR: begin
          addr_q  <= addr_nxt;
          cnt_q   <= cnt_q - 1'b1;
          wlast_q <= (state == ST_WR) && (cnt_q == 7'd1);
          if (cnt_q == '0) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            wack_q  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign nib_en = wmsk_to_nib(mi_wmsk);

  for (genvar b = 0; b < NB; b++) begin : g_bank
    mc_spram_bank u_bank (
      .clk    (clk),
      .addr   (addr_q[BANK_AW-1:0]),
      .wdata  (mi_wdata),
      .nib_en (nib_en),
      .we     (wack_q),
      .cs     ((wack_q || state == ST_RD) && (addr_q[AW-1:BANK_AW] == BW'(b))),
      .rdata  (bank_rd[b])
    );
  end

  assign mi_ready = ready_q;
  assign mi_wack  = wack_q;
  assign mi_wlast = wlast_q;
  assign mi_rstb  = rstb_q;
  assign mi_rlast = rlast_q;
  assign mi_rdata = rstb_q ? bank_rd[rd_sel_q] : '0;
endmodule

// File: tb/tb_mc_spram_mi.sv
// tb/tb_mc_spram_mi.sv - directed and randomized bench for mc_spram_mi against a word-array model
module tb_mc_spram_mi;
  localparam int AW    = 15;
  localparam int DEPTH = 1 << AW;
`ifdef MC_SPRAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] mi_addr = '0;
  logic [6:0]  mi_len = '0;
  logic        mi_rw = 1'b0, mi_linear = 1'b1, mi_valid = 1'b0;
  logic        mi_ready;
  logic [31:0] mi_wdata = '0;
  logic [3:0]  mi_wmsk = '0;
  logic        mi_wack, mi_wlast, mi_rstb, mi_rlast;
  logic [31:0] mi_rdata;

  always #5 clk = ~clk;

  mc_spram_mi #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw),
    .mi_linear(mi_linear), .mi_valid(mi_valid), .mi_ready(mi_ready),
    .mi_wdata(mi_wdata), .mi_wmsk(mi_wmsk), .mi_wack(mi_wack), .mi_wlast(mi_wlast),
    .mi_rdata(mi_rdata), .mi_rstb(mi_rstb), .mi_rlast(mi_rlast)
  );

  logic [31:0] ref_mem [DEPTH];
  bit          known [DEPTH];
  logic [31:0] wbuf [128];
  logic [3:0]  mbuf [128];
  logic [31:0] cap [128];
  int          n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // i-th word address of a burst, from the burst rules rather than any mask arithmetic
  function automatic int unsigned burst_addr(input int unsigned start, input int len,
                                             input bit lin, input int i);
    int unsigned bs, base, off;
    if (WRAP_EN && !lin) begin
      bs = 1;
      while (bs < len + 1) bs = bs * 2;
      base = (start / bs) * bs;
      off  = (start % bs + i) % bs;
      return (base + off) % DEPTH;
    end
    return (start + i) % DEPTH;
  endfunction

  task automatic ref_write(input int unsigned idx, input logic [31:0] d, input logic [3:0] m);
    for (int b = 0; b < 4; b++)
      if (!m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    if (m == 4'b0000) known[idx] = 1'b1;
  endtask

  // called on a negedge; returns on the negedge of the cycle after acceptance
  task automatic issue(input logic [23:0] a, input int len, input bit rw, input bit lin);
    int n;
    n = 0;
    mi_addr = a; mi_len = 7'(len); mi_rw = rw; mi_linear = lin; mi_valid = 1'b1;
    while (mi_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_bit("cmd_ready", mi_ready, 1'b1);
    @(negedge clk);
    mi_valid = 1'b0;
  endtask

  task automatic do_write(input logic [23:0] a, input int len, input bit lin, input int abort_at);
    issue(a, len, 1'b0, lin);
    for (int i = 0; i <= len; i++) begin
      mi_wdata = wbuf[i];
      mi_wmsk  = mbuf[i];
      check_bit("wack", mi_wack, 1'b1);
      check_bit("wlast", mi_wlast, i == len);
      ref_write(burst_addr(a, len, lin, i), wbuf[i], mbuf[i]);
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_bit("rst_wack", mi_wack, 1'b0);
        check_bit("rst_ready", mi_ready, 1'b0);
        check_bit("rst_rstb", mi_rstb, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_bit("ready_after_rst", mi_ready, 1'b1);
        return;
      end
      @(negedge clk);
    end
    check_bit("wack_end", mi_wack, 1'b0);
    mi_wmsk = 4'b0000;
  endtask

  task automatic do_read(input logic [23:0] a, input int len, input bit lin);
    int unsigned idx;
    issue(a, len, 1'b1, lin);
    check_bit("rstb_t1", mi_rstb, 1'b0);
    @(negedge clk);
    for (int i = 0; i <= len; i++) begin
      check_bit("rstb", mi_rstb, 1'b1);
      check_bit("rlast", mi_rlast, i == len);
      cap[i] = mi_rdata;
      idx = burst_addr(a, len, lin, i);
      if (known[idx]) check("rdata", mi_rdata, ref_mem[idx]);
      @(negedge clk);
    end
    check_bit("rstb_end", mi_rstb, 1'b0);
  endtask

  initial begin
    logic [31:0] v;
    int          len, n;
    bit          lin, drop;
    logic        stb_q[14], last_q[14];
    logic [31:0] dat_q[14];

    repeat (3) @(negedge clk);
    check_bit("reset_ready", mi_ready, 1'b0);
    check_bit("reset_wack", mi_wack, 1'b0);
    check_bit("reset_wlast", mi_wlast, 1'b0);
    check_bit("reset_rstb", mi_rstb, 1'b0);
    check_bit("reset_rlast", mi_rlast, 1'b0);
    check("reset_rdata", mi_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_bit("ready_after_reset", mi_ready, 1'b1);

    // 16-word linear write and read-back, read issued back-to-back after the write
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'hA000_0000 + i; mbuf[i] = 4'b0000; end
    do_write(24'h000100, 15, 1'b1, -1);
    do_read(24'h000100, 15, 1'b1);

    // byte mask
    wbuf[0] = 32'hFFFF_FFFF; mbuf[0] = 4'b0000;
    do_write(24'h000200, 0, 1'b1, -1);
    wbuf[0] = 32'h1234_5678; mbuf[0] = 4'b0101;
    do_write(24'h000200, 0, 1'b1, -1);
    do_read(24'h000200, 0, 1'b1);
    check("mask_merge", cap[0], 32'h12FF_56FF);

    // wrap (or linear when wrapping is compiled out) inside block 0x100
    do_read(24'h000105, 7, 1'b0);
    check("wrap_w0", cap[0], 32'hA000_0005);
    check("wrap_w3", cap[3], WRAP_EN ? 32'hA000_0000 : 32'hA000_0008);
    check("wrap_w7", cap[7], WRAP_EN ? 32'hA000_0004 : 32'hA000_000C);

    // two reads with mi_valid held: one idle cycle between the strobe runs
    mi_addr = 24'h000100; mi_len = 7'd3; mi_rw = 1'b1; mi_linear = 1'b1; mi_valid = 1'b1;
    n = 0;
    while (mi_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check_bit("b2b_ready", mi_ready, 1'b1);
    @(negedge clk);
    mi_addr = 24'h000108;
    drop = 1'b0;
    for (int c = 0; c < 14; c++) begin
      stb_q[c] = mi_rstb; last_q[c] = mi_rlast; dat_q[c] = mi_rdata;
      if (drop) mi_valid = 1'b0;
      drop = mi_valid && mi_ready;
      @(negedge clk);
    end
    mi_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      check_bit("b2b_rstb", stb_q[c], (c >= 1 && c <= 4) || (c >= 6 && c <= 9));
      check_bit("b2b_rlast", last_q[c], c == 4 || c == 9);
      if (c >= 1 && c <= 4) check("b2b_data_a", dat_q[c], ref_mem[32'h100 + c - 1]);
      if (c >= 6 && c <= 9) check("b2b_data_b", dat_q[c], ref_mem[32'h108 + c - 6]);
    end

    // reset during the 4th write acknowledge
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'h5500_0000 + i; mbuf[i] = 4'b0000; end
    do_write(24'h000300, 15, 1'b1, -1);
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h6600_0000 + i;
    do_write(24'h000300, 15, 1'b1, 3);
    do_read(24'h000300, 15, 1'b1);
    check("rst_word3", cap[3], 32'h6600_0003);
    check("rst_word4", cap[4], 32'h5500_0004);

    // high address bits alias
    v = $urandom;
    wbuf[0] = v; mbuf[0] = 4'b0000;
    do_write(24'h008100, 0, 1'b1, -1);
    do_read(24'h000100, 0, 1'b1);
    check("alias", cap[0], v);

    // maximum length burst crossing the top of memory and the bank boundary
    for (int i = 0; i < 128; i++) begin wbuf[i] = $urandom; mbuf[i] = 4'b0000; end
    do_write(24'h007FC0, 127, 1'b1, -1);
    do_read(24'h007FC0, 127, 1'b1);
    do_read(24'h003FF0, 31, 1'b1);

    // randomized bursts
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 20);
      lin = 1'($urandom_range(0, 1));
      v   = $urandom;
      for (int i = 0; i <= len; i++) begin
        wbuf[i] = $urandom;
        mbuf[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      end
      do_write(v[23:0], len, lin, -1);
      do_read(v[23:0], len, lin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
